// File: rtl/track_selector.sv
// track_selector: registered MP3 track index driven by PREV/NEXT/EOT/LOAD with wrap or clamp and a button lockout.
// Define TRACK_SEL_EDGE_EN for edge-triggered PREV/NEXT; otherwise requests are level-sensitive.

module track_step #(
  parameter int TRACK_W    = 3,
  parameter int NUM_TRACKS = 8,
  parameter int STEP_W     = 3,
  parameter int WRAP       = 1
) (
  input  logic [TRACK_W-1:0] sw,
  input  logic [STEP_W-1:0]  step,
  input  logic               dn,
  output logic [TRACK_W-1:0] res
);
  localparam int AW = TRACK_W + STEP_W + 1;
  localparam logic [AW-1:0] NT  = AW'(NUM_TRACKS);
  localparam logic [AW-1:0] TOP = AW'(NUM_TRACKS - 1);

  logic [AW-1:0] sw_x, st_x, up, r;

  assign sw_x = AW'(sw);
  assign st_x = AW'(step);
  assign up   = sw_x + st_x;

  generate
    if (WRAP != 0) begin : g_wrap
      logic [AW-1:0] st_m, dn_w;
      assign st_m = st_x % NT;
      // sw < NT and st_m < NT, so dn_w lies in [1, 2*NT) and one subtract folds it
      assign dn_w = sw_x + NT - st_m;
      always_comb begin
        if (dn) r = (dn_w >= NT) ? dn_w - NT : dn_w;
        else    r = up % NT;
      end
    end else begin : g_clamp
      always_comb begin
        if (dn) r = (st_x > sw_x) ? '0 : sw_x - st_x;
        else    r = (up > TOP) ? TOP : up;
      end
    end
  endgenerate

  assign res = TRACK_W'(r);
endmodule

module track_selector #(
  parameter int TRACK_W     = 3,
  parameter int NUM_TRACKS  = 8,
  parameter int STEP_W      = 3,
  parameter int LOCK_CYCLES = 500000,
  parameter int WRAP        = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [STEP_W-1:0]  PREV,
  input  logic [STEP_W-1:0]  NEXT,
  input  logic               EOT,
  input  logic               LOAD,
  input  logic [TRACK_W-1:0] LOAD_VAL,
  output logic [TRACK_W-1:0] SW,
  output logic               CHANGE,
  output logic               BUSY
);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   LOCK_LD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [TRACK_W-1:0] TOP     = TRACK_W'(NUM_TRACKS - 1);

  logic [CNT_W-1:0]   lock_cnt;
  logic [STEP_W-1:0]  prev_req, next_req;
  logic               idle, acc_prev, acc_next, accept;
  logic [STEP_W-1:0]  step;
  logic               dn;
  logic [TRACK_W-1:0] step_res, sw_nxt;

`ifdef TRACK_SEL_EDGE_EN
  logic [STEP_W-1:0] prev_q, next_q;

  // Previous bus values track the raw inputs even during lockout, so a press
  // whose rising edge lands in the lockout is lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_q <= '0;
      next_q <= '0;
    end else begin
      prev_q <= PREV;
      next_q <= NEXT;
    end
  end

  assign prev_req = (prev_q == '0) ? PREV : '0;
  assign next_req = (next_q == '0) ? NEXT : '0;
`else
  assign prev_req = PREV;
  assign next_req = NEXT;
`endif

  assign idle     = (lock_cnt == '0);
  assign acc_prev = !LOAD && idle && (prev_req != '0);
  assign acc_next = !LOAD && idle && (prev_req == '0) && (next_req != '0);
  assign accept   = acc_prev || acc_next;

  // One shared adder: the chosen event decides step size and direction
  always_comb begin
    step = STEP_W'(1);
    dn   = 1'b0;
    if (acc_prev) begin
      step = prev_req;
      dn   = 1'b1;
    end else if (acc_next) begin
      step = next_req;
    end
  end

  track_step #(
    .TRACK_W    (TRACK_W),
    .NUM_TRACKS (NUM_TRACKS),
    .STEP_W     (STEP_W),
    .WRAP       (WRAP)
  ) u_step (
    .sw   (SW),
    .step (step),
    .dn   (dn),
    .res  (step_res)
  );

  always_comb begin
    sw_nxt = SW;
    if (LOAD)               sw_nxt = (LOAD_VAL > TOP) ? TOP : LOAD_VAL;
    else if (accept || EOT) sw_nxt = step_res;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SW       <= '0;
      CHANGE   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      SW     <= sw_nxt;
      CHANGE <= (sw_nxt != SW);
      if (accept)     lock_cnt <= LOCK_LD;
      else if (!idle) lock_cnt <= lock_cnt - CNT_W'(1);
    end
  end

  assign BUSY = !idle;
endmodule

// File: tb/tb_track_selector.sv
// Bench for track_selector: directed scenarios plus random traffic on a wrap and a clamp instance,
// scored against a cycle-indexed arithmetic model.
module tb_track_selector;
  localparam int TW = 3, NT = 5, SWD = 2, LC = 4;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic [SWD-1:0] prev_b = '0, next_b = '0;
  logic           eot = 1'b0, load = 1'b0;
  logic [TW-1:0]  lval = '0;
  logic [TW-1:0]  sw_w, sw_c;
  logic           chg_w, chg_c, busy_w, busy_c;

  always #5 clk = ~clk;

  track_selector #(.TRACK_W(TW), .NUM_TRACKS(NT), .STEP_W(SWD), .LOCK_CYCLES(LC), .WRAP(1)) u_wrap (
    .CLK(clk), .RST_N(rst_n), .PREV(prev_b), .NEXT(next_b), .EOT(eot), .LOAD(load),
    .LOAD_VAL(lval), .SW(sw_w), .CHANGE(chg_w), .BUSY(busy_w));

  track_selector #(.TRACK_W(TW), .NUM_TRACKS(NT), .STEP_W(SWD), .LOCK_CYCLES(LC), .WRAP(0)) u_clamp (
    .CLK(clk), .RST_N(rst_n), .PREV(prev_b), .NEXT(next_b), .EOT(eot), .LOAD(load),
    .LOAD_VAL(lval), .SW(sw_c), .CHANGE(chg_c), .BUSY(busy_c));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Model: index 1 = wrap instance, index 0 = clamp instance.
  // Lockout is kept as "first edge number at which a press may be accepted".
  int m_sw[2], m_chg[2];
  int m_edge = 0, m_ok = 0, m_pq = 0, m_nq = 0;
  bit m_busy;

  function automatic int mstep(int s, int d, bit wrap);
    int r;
    r = s + d;
    if (wrap) begin
      r = r % NT;
      if (r < 0) r += NT;
    end else begin
      if (r < 0) r = 0;
      if (r > NT - 1) r = NT - 1;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_sw[0] = 0; m_sw[1] = 0; m_chg[0] = 0; m_chg[1] = 0;
    m_ok = 0; m_pq = 0; m_nq = 0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    int pr, nr;
    bit can, acc;
    m_edge++;
`ifdef TRACK_SEL_EDGE_EN
    pr = (m_pq == 0) ? int'(prev_b) : 0;
    nr = (m_nq == 0) ? int'(next_b) : 0;
    m_pq = int'(prev_b);
    m_nq = int'(next_b);
`else
    pr = int'(prev_b);
    nr = int'(next_b);
`endif
    can = (m_edge >= m_ok);
    acc = !load && can && (pr != 0 || nr != 0);
    for (int w = 0; w < 2; w++) begin
      int nw;
      if (load)     nw = (int'(lval) > NT - 1) ? NT - 1 : int'(lval);
      else if (acc) nw = mstep(m_sw[w], (pr != 0) ? -pr : nr, w[0]);
      else if (eot) nw = mstep(m_sw[w], 1, w[0]);
      else          nw = m_sw[w];
      m_chg[w] = (nw != m_sw[w]) ? 1 : 0;
      m_sw[w]  = nw;
    end
    if (acc) m_ok = m_edge + LC;
    m_busy = (m_edge + 1 < m_ok);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/sw_wrap"},    int'(sw_w),   m_sw[1]);
    chk({tag, "/sw_clamp"},   int'(sw_c),   m_sw[0]);
    chk({tag, "/chg_wrap"},   int'(chg_w),  m_chg[1]);
    chk({tag, "/chg_clamp"},  int'(chg_c),  m_chg[0]);
    chk({tag, "/busy_wrap"},  int'(busy_w), int'(m_busy));
    chk({tag, "/busy_clamp"}, int'(busy_c), int'(m_busy));
  endtask

  // Called at a negedge; drives inputs, takes one posedge, checks, returns at the next negedge.
  task automatic cyc(input int p, input int n, input int e, input int l, input int lv, input string tag);
    prev_b = SWD'(p); next_b = SWD'(n); eot = e[0]; load = l[0]; lval = TW'(lv);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, "idle");
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "/rst_sw"},   int'(sw_w) + int'(sw_c), 0);
    chk({tag, "/rst_busy"}, int'(busy_w) + int'(busy_c), 0);
    chk({tag, "/rst_chg"},  int'(chg_w) + int'(chg_c), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset/sw",   int'(sw_w),   0);
    chk("reset/busy", int'(busy_w), 0);
    chk("reset/chg",  int'(chg_w),  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // single step and lockout
    cyc(0, 1, 0, 0, 0, "step1");
    chk("step1/sw", int'(sw_w), 1);
    chk("step1/chg", int'(chg_w), 1);
    idle(1);
    cyc(0, 1, 0, 0, 0, "locked");
    chk("locked/sw", int'(sw_w), 1);
    idle(1);
    chk("lock_end/busy", int'(busy_w), 0);

    // wrap vs clamp at the top, wrap below zero
    cyc(0, 0, 0, 1, 4, "ld4");
    cyc(0, 2, 0, 0, 0, "top");
    chk("top/sw_wrap", int'(sw_w), 1);
    chk("top/sw_clamp", int'(sw_c), 4);
    chk("top/chg_clamp", int'(chg_c), 0);
    chk("top/busy_clamp", int'(busy_c), 1);
    idle(3);
    cyc(0, 0, 0, 1, 1, "ld1");
    cyc(3, 0, 0, 0, 0, "bot");
    chk("bot/sw_wrap", int'(sw_w), 3);
    chk("bot/sw_clamp", int'(sw_c), 0);
    idle(3);

    // held button
    cyc(0, 0, 0, 1, 0, "ld0");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, "hold");
`ifdef TRACK_SEL_EDGE_EN
    chk("hold/sw", int'(sw_w), 1);
`else
    chk("hold/sw", int'(sw_w), 3);
`endif
    idle(4);

    // simultaneous events
    cyc(0, 0, 0, 1, 2, "ld2");
    cyc(1, 1, 0, 0, 0, "pn");
    chk("pn/sw", int'(sw_w), 1);
    idle(3);
    cyc(0, 0, 0, 1, 2, "ld2b");
    cyc(0, 1, 1, 0, 0, "neot");
    chk("neot/sw", int'(sw_w), 3);
    cyc(0, 0, 1, 0, 0, "eotbusy");
    chk("eotbusy/sw", int'(sw_w), 4);
    idle(2);
    chk("eotbusy/busy_end", int'(busy_w), 0);

    // load clamp, no-change load, load beats a press
    cyc(0, 0, 0, 1, 0, "ld0b");
    cyc(0, 0, 0, 1, 7, "ld7");
    chk("ld7/sw", int'(sw_w), 4);
    chk("ld7/chg", int'(chg_w), 1);
    cyc(0, 0, 0, 1, 3, "ld3");
    cyc(0, 0, 0, 1, 3, "ld3b");
    chk("ld3b/chg", int'(chg_w), 0);
    cyc(0, 1, 0, 1, 0, "ldnext");
    chk("ldnext/sw", int'(sw_w), 0);
    chk("ldnext/busy", int'(busy_w), 0);
    idle(1);

    // reset mid-lockout, then a press on the first edge
    cyc(0, 0, 0, 1, 2, "ld2c");
    cyc(0, 1, 0, 0, 0, "pre_rst");
    chk("pre_rst/sw", int'(sw_w), 3);
    do_reset("midlock");
    cyc(0, 1, 0, 0, 0, "post_rst");
    chk("post_rst/sw", int'(sw_w), 1);
    idle(4);

    // random traffic with held buses
    begin
      int pb = 0, nb = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 3) == 0) pb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : 0;
        if ($urandom_range(0, 3) == 0) nb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : 0;
        if ($urandom_range(0, 299) == 0) do_reset("rnd");
        cyc(pb, nb, ($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 15) == 0) ? 1 : 0,
            int'($urandom_range(0, 7)), "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/track_selector.md
# track_selector

Parametrised track-index selector for the MP3 player front panel. It converts debounced PREV/NEXT step requests, a decoder end-of-track pulse and a direct-load request into a registered track index `SW`. It supports a non-power-of-two track count, wrap or clamp at the ends, and a configurable lockout between button steps. It sits between the button/keypad logic and the SD-card/decoder track fetch, and replaces the fixed 3-bit selector.

## Interface
- `TRACK_W`, 3: width of `SW` and `LOAD_VAL`.
- `NUM_TRACKS`, 8: number of valid tracks. Range 2..2^TRACK_W. Valid indices are 0..NUM_TRACKS-1.
- `STEP_W`, 3: width of the PREV/NEXT step buses.
- `LOCK_CYCLES`, 500000: lockout length in CLK cycles between accepted button steps. Must be ≥1.
- `WRAP`, 1: 1 = wrap modulo NUM_TRACKS; 0 = clamp at 0 and NUM_TRACKS-1.

Ports:
- `CLK` input 1: system clock; all registers update on the rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `PREV` input STEP_W: step-back request. Nonzero value = step size.
- `NEXT` input STEP_W: step-forward request. Nonzero value = step size.
- `EOT` input 1: end-of-track pulse from the decoder; advances by 1.
- `LOAD` input 1: direct-select strobe.
- `LOAD_VAL` input TRACK_W: track index applied on `LOAD`.
- `SW` output TRACK_W: current track index (registered).
- `CHANGE` output 1: one-cycle pulse when `SW` changed value.
- `BUSY` output 1: high while the button lockout is running.

## Operation
- Reset (asynchronous, immediate):
  - `SW`=0, `CHANGE`=0, `BUSY`=0.
  - Lockout counter = 0.
  - Previous-button register = 0.
- Priority at each edge: LOAD > accepted PREV > accepted NEXT > EOT. Only one action is applied per edge; lower-priority events in the same cycle are dropped.
- Button acceptance: a PREV/NEXT request is accepted only when the lockout counter is 0. If PREV and NEXT are both nonzero, PREV wins.
- On acceptance the lockout counter loads LOCK_CYCLES-1. It decrements by 1 per cycle while nonzero. `BUSY` = (counter ≠ 0).
- A request arriving while `BUSY` is high is ignored (not queued).
- Arithmetic:
  - Compute in TRACK_W+STEP_W+1 bits, unsigned.
  - NEXT: `SW`+step.
  - PREV: `SW`−step.
  - WRAP=1: result taken modulo NUM_TRACKS. This holds for any step, including steps ≥ NUM_TRACKS.
  - WRAP=0: result saturates at NUM_TRACKS-1 (NEXT) or 0 (PREV).
- EOT: applies +1 with the same wrap/clamp rule. It is accepted regardless of `BUSY` and neither starts nor alters the lockout.
- LOAD: `SW` ← `LOAD_VAL`. Values ≥ NUM_TRACKS clamp to NUM_TRACKS-1. LOAD ignores and does not alter the lockout.
- `CHANGE` pulses only if the new `SW` differs from the old value. An accepted press that saturates with no change still starts the lockout.

## Timing
- Latency: inputs are sampled at edge t; `SW` and `CHANGE` are valid after edge t. `CHANGE` is high for exactly the one cycle following edge t.
- Lockout: after a press is accepted at edge t, the next press can be accepted no earlier than edge t+LOCK_CYCLES. `BUSY` is high for LOCK_CYCLES-1 cycles.
- LOCK_CYCLES=1 allows back-to-back accepted presses with `BUSY` never asserted.
- Reset asserted mid-lockout clears everything at once. The first edge after `RST_N` rises can accept a press.

## Configuration
- `TRACK_SEL_EDGE_EN` defined (edge mode):
  - A request counts only on the cycle where the bus is nonzero and the previous-cycle value (registered, reset 0) was zero.
  - A held button steps once.
  - A press whose edge falls during lockout is lost, even if the button is still held afterwards.
- `TRACK_SEL_EDGE_EN` undefined (level mode):
  - Requests are level-sensitive.
  - A held button re-steps every LOCK_CYCLES cycles.
  - No previous-value register is built.

## Test plan
All scenarios use NUM_TRACKS=5, TRACK_W=3, STEP_W=2, LOCK_CYCLES=4.
- Reset, then NEXT=1 for one cycle -> `SW` 0→1; `CHANGE` high 1 cycle; `BUSY` high 3 cycles; NEXT=1 two cycles later is ignored.
- Wrap/clamp:
  - `SW`=4, NEXT=2: WRAP=1 -> `SW`=1. WRAP=0 -> `SW`=4, no `CHANGE`, `BUSY` still asserted.
  - `SW`=1, PREV=3, WRAP=1 -> `SW`=3.
- Hold NEXT=1 for 10 cycles from `SW`=0 -> level mode: accepts at edges t, t+4, t+8, final `SW`=3. Edge mode: final `SW`=1.
- Simultaneous events at `SW`=2:
  - PREV=1 and NEXT=1 together -> `SW`=1.
  - EOT with an accepted NEXT=1 -> `SW`=3 only.
  - EOT during `BUSY` -> `SW` +1, `BUSY` deassert time unchanged.
- LOAD_VAL=7 -> `SW`=4 with `CHANGE`. LOAD_VAL=3 while `SW`=3 -> no `CHANGE`. LOAD together with NEXT -> LOAD applied, no lockout started.
- `RST_N` low mid-lockout at `SW`=3 -> `SW`=0, `BUSY`=0 without waiting for a clock edge. After release, NEXT=1 is accepted at the first edge -> `SW`=1.
